instruction_encoder: RTL and testbench

- Inverse of the instruction decoder. Takes a one-hot instruction select (same 16-bit bit ordering the decoder produces) plus a 16-bit address operand.
- Serialises the instruction into program-memory bytes: an opcode byte, then the operand low and high bytes for memory-referencing instructions.
- Sits between the program loader / debug port and the program RAM write port. Drives an auto-incrementing write address.

---
 rtl/cpu_isa_pkg.sv | 47 ++++
 rtl/onehot_to_opcode.sv | 24 ++
 rtl/instruction_encoder.sv | 110 +++++++++++
 tb/tb_instruction_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder: opcodes,
// one-hot bit positions and operand classification.
package cpu_isa_pkg;

    typedef enum logic [7:0] {
        OpNop  = 8'h00,
        OpLdac = 8'h01,
        OpStac = 8'h02,
        OpMvac = 8'h03,
        OpMovr = 8'h04,
        OpJump = 8'h05,
        OpJmpz = 8'h06,
        OpJpnz = 8'h07,
        OpAdd  = 8'h08,
        OpSub  = 8'h09,
        OpInac = 8'h0A,
        OpClac = 8'h0B,
        OpAnd  = 8'h0C,
        OpOr   = 8'h0D,
        OpXor  = 8'h0E,
        OpNot  = 8'h0F
    } opcode_t;

    localparam int unsigned BitNop  = 0;
    localparam int unsigned BitLdac = 1;
    localparam int unsigned BitStac = 2;
    localparam int unsigned BitMvac = 3;
    localparam int unsigned BitMovr = 4;
    localparam int unsigned BitJump = 5;
    localparam int unsigned BitJmpz = 6;
    localparam int unsigned BitJpnz = 7;
    localparam int unsigned BitAdd  = 8;
    localparam int unsigned BitSub  = 9;
    localparam int unsigned BitInac = 10;
    localparam int unsigned BitClac = 11;
    localparam int unsigned BitAnd  = 12;
    localparam int unsigned BitOr   = 13;
    localparam int unsigned BitXor  = 14;
    localparam int unsigned BitNot  = 15;

    // Memory-referencing instructions carry a 16-bit address operand.
    function automatic logic has_operand(opcode_t op);
        return (op == OpLdac) || (op == OpStac) || (op == OpJump) ||
               (op == OpJmpz) || (op == OpJpnz);
    endfunction

endpackage

// File: rtl/onehot_to_opcode.sv
// Converts a 16-bit one-hot instruction select into its opcode; anything that
// is not exactly one-hot maps to NOP with valid_o low.
module onehot_to_opcode
    import cpu_isa_pkg::*;
(
    input  logic [15:0] onehot_i,
    output opcode_t     opcode_o,
    output logic        valid_o
);

    logic [3:0] idx;

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (onehot_i[i]) begin
                idx = 4'(i);
            end
        end
        valid_o  = ($countones(onehot_i) == 1);
        opcode_o = valid_o ? opcode_t'({4'b0000, idx}) : OpNop;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Serialises one-hot instruction requests into program-memory bytes
// (opcode, then operand low/high for memory-referencing instructions).
module instruction_encoder
    import cpu_isa_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]    START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_onehot,
    input  logic [15:0]       in_operand,
    input  logic              clear_ptr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_onehot,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {StIdle, StOpc, StLo, StHi} state_e;

    state_e            state_q;
    opcode_t           opcode_q;
    logic [15:0]       operand_q;
    logic              out_valid_q;
    logic [7:0]        out_byte_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_q;
    logic [15:0]       count_q;

    opcode_t           dec_opcode;
    logic              dec_valid;

    onehot_to_opcode u_onehot_to_opcode (
        .onehot_i (in_onehot),
        .opcode_o (dec_opcode),
        .valid_o  (dec_valid)
    );

    // Gated by reset_n so no request is taken while reset is asserted.
    assign in_ready    = reset_n && (state_q == StIdle) && !clear_ptr;
    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_addr    = out_addr_q;
    assign err_onehot  = err_q;
    assign instr_count = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            opcode_q    <= OpNop;
            operand_q   <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_addr_q  <= START_ADDR;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_ptr) begin
                        out_addr_q <= START_ADDR;
                    end else if (in_valid) begin
                        state_q     <= StOpc;
                        opcode_q    <= dec_opcode;
                        operand_q   <= in_operand;
                        out_valid_q <= 1'b1;
                        out_byte_q  <= dec_opcode;
                        err_q       <= !dec_valid;
                    end
                end
                StOpc: begin
                    if (out_ready) begin
                        out_addr_q <= out_addr_q + 1'b1;
                        if (has_operand(opcode_q)) begin
                            state_q    <= StLo;
                            out_byte_q <= operand_q[7:0];
                        end else begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            count_q     <= count_q + 16'd1;
                        end
                    end
                end
                StLo: begin
                    if (out_ready) begin
                        out_addr_q <= out_addr_q + 1'b1;
                        state_q    <= StHi;
                        out_byte_q <= operand_q[15:8];
                    end
                end
                StHi: begin
                    if (out_ready) begin
                        out_addr_q  <= out_addr_q + 1'b1;
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a 16-bit-address instance for the
// main sequences and a 4-bit-address instance for the address wrap.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_onehot;
    logic [15:0] in_operand;
    logic        clear_ptr;
    logic        out_ready;

    logic        in_ready, out_valid, err_onehot;
    logic [7:0]  out_byte;
    logic [15:0] out_addr, instr_count;

    logic        rdy4, v4, err4;
    logic [7:0]  b4;
    logic [3:0]  a4;
    logic [15:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(16), .START_ADDR(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_onehot(in_onehot), .in_operand(in_operand), .clear_ptr(clear_ptr),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_addr(out_addr), .err_onehot(err_onehot), .instr_count(instr_count)
    );

    instruction_encoder #(.ADDR_W(4), .START_ADDR(4'h0)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_onehot(in_onehot), .in_operand(in_operand), .clear_ptr(clear_ptr),
        .out_valid(v4), .out_ready(out_ready), .out_byte(b4),
        .out_addr(a4), .err_onehot(err4), .instr_count(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] b,
                           input logic [15:0] a);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_byte"}, out_byte, b);
        check({tag, "_addr"}, out_addr, a);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_onehot = '0; in_operand = '0;
        clear_ptr = 1'b0; out_ready = 1'b1;
        #2;
        chk_out("rst", 1'b0, 8'h00, 16'h0000);
        check("rst_err", err_onehot, 1'b0);
        check("rst_cnt", instr_count, 16'h0000);
        check("rst_ready", in_ready, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        check("idle_ready", in_ready, 1'b1);

        // LDAC 0x1234
        in_valid = 1'b1; in_onehot = 16'h0002; in_operand = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk_out("ldac_opc", 1'b1, 8'h01, 16'h0000);
        check("ldac_busy", in_ready, 1'b0);
        tick();
        chk_out("ldac_lo", 1'b1, 8'h34, 16'h0001);
        tick();
        chk_out("ldac_hi", 1'b1, 8'h12, 16'h0002);
        tick();
        check("ldac_done", out_valid, 1'b0);
        check("ldac_cnt", instr_count, 16'd1);
        check("ldac_ready", in_ready, 1'b1);

        // Pointer clear, then CLAC and NOT back to back
        clear_ptr = 1'b1;
        tick();
        clear_ptr = 1'b0;
        check("clr_addr", out_addr, 16'h0000);
        in_valid = 1'b1; in_onehot = 16'h0800; in_operand = 16'hFFFF;
        tick();
        in_onehot = 16'h8000;
        chk_out("clac", 1'b1, 8'h0B, 16'h0000);
        check("clac_busy", in_ready, 1'b0);
        tick();
        check("clac_done", out_valid, 1'b0);
        check("clac_cnt", instr_count, 16'd2);
        tick();
        in_valid = 1'b0;
        chk_out("not", 1'b1, 8'h0F, 16'h0001);
        tick();
        check("not_done", out_valid, 1'b0);
        check("not_cnt", instr_count, 16'd3);

        // JUMP 0xBEEF with backpressure on the low byte
        in_valid = 1'b1; in_onehot = 16'h0020; in_operand = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk_out("jump_opc", 1'b1, 8'h05, 16'h0002);
        tick();
        out_ready = 1'b0;
        chk_out("jump_lo", 1'b1, 8'hEF, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("jump_stall", 1'b1, 8'hEF, 16'h0003);
        end
        out_ready = 1'b1;
        tick();
        chk_out("jump_hi", 1'b1, 8'hBE, 16'h0004);
        tick();
        check("jump_cnt", instr_count, 16'd4);

        // Invalid one-hot vectors encode as NOP with an error pulse
        in_valid = 1'b1; in_onehot = 16'h0000; in_operand = 16'h5555;
        tick();
        in_valid = 1'b0;
        chk_out("zero_opc", 1'b1, 8'h00, 16'h0005);
        check("zero_err", err_onehot, 1'b1);
        tick();
        check("zero_err_off", err_onehot, 1'b0);
        check("zero_done", out_valid, 1'b0);
        check("zero_cnt", instr_count, 16'd5);
        in_valid = 1'b1; in_onehot = 16'h0003; in_operand = 16'hAAAA;
        tick();
        in_valid = 1'b0;
        chk_out("multi_opc", 1'b1, 8'h00, 16'h0006);
        check("multi_err", err_onehot, 1'b1);
        tick();
        check("multi_err_off", err_onehot, 1'b0);
        check("multi_done", out_valid, 1'b0);
        check("multi_cnt", instr_count, 16'd6);

        // clear_ptr beats in_valid
        check("pre_clr_addr", out_addr, 16'h0007);
        clear_ptr = 1'b1; in_valid = 1'b1; in_onehot = 16'h0001;
        #1;
        check("clr_ready", in_ready, 1'b0);
        tick();
        clear_ptr = 1'b0; in_valid = 1'b0;
        check("clr_noaccept", out_valid, 1'b0);
        check("clr_addr2", out_addr, 16'h0000);

        // Reset during the HI byte
        in_valid = 1'b1; in_onehot = 16'h0002; in_operand = 16'h4321;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk_out("rst_hi", 1'b1, 8'h43, 16'h0002);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_addr", out_addr, 16'h0000);
        check("midrst_cnt", instr_count, 16'h0000);
        check("midrst_ready", in_ready, 1'b0);
        tick();
        reset_n = 1'b1;

        // Address wrap on the 4-bit instance: 15 NOPs then STAC 0xA5C3
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_onehot = 16'h0001;
            tick();
            in_valid = 1'b0;
            tick();
        end
        check("wrap_pre_addr", a4, 4'hF);
        in_valid = 1'b1; in_onehot = 16'h0004; in_operand = 16'hA5C3;
        tick();
        in_valid = 1'b0;
        check("wrap_opc_b", b4, 8'h02);
        check("wrap_opc_a", a4, 4'hF);
        tick();
        check("wrap_lo_b", b4, 8'hC3);
        check("wrap_lo_a", a4, 4'h0);
        tick();
        check("wrap_hi_b", b4, 8'hA5);
        check("wrap_hi_a", a4, 4'h1);
        check("wrap_hi_v", v4, 1'b1);
        tick();
        check("wrap_done", v4, 1'b0);
        check("wrap_cnt", cnt4, 16'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
